// File: rtl/datapath_wall.sv
// datapath_wall: moving-wall datapath with its own sequencing FSM.
// Each accepted move (go && frame_tick while idle) runs these phases:
//   ERASE - paint the current wall column black, rows 0..119
//   STEP  - move the wall one column left; wrap 0 -> 159 with a new random gap
//   DRAW  - repaint the column in WALL_COLOUR, skipping the gap rows
//   CHECK - test the player against the wall; the result appears on touched
//           one cycle later.
// Ports:
//   clk, reset                    clock, async active-high reset
//   go, frame_tick                move enable and per-frame pulse
//   player_y                      player row, used for the collision test
//   touched                       registered one-cycle collision pulse
//   wall_x, gap_y                 current wall column and top row of the gap
//   vga_x, vga_y, vga_colour, plot  pixel-write port to the VGA adapter
module datapath_wall #(
  parameter logic [7:0] PLAYER_X    = 8'd20,
  parameter logic [6:0] GAP         = 7'd24,
  parameter logic [2:0] WALL_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       frame_tick,
  input  logic [6:0] player_y,
  output logic       touched,
  output logic [7:0] wall_x,
  output logic [6:0] gap_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ERASE = 3'd1;
  localparam logic [2:0] STEP  = 3'd2;
  localparam logic [2:0] DRAW  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;

  localparam logic [6:0] LAST_ROW = 7'd119;
  localparam logic [7:0] LAST_COL = 8'd159;
  localparam logic [6:0] GAP_MAX  = 7'd96;
  localparam logic [6:0] SEED     = 7'h5A;

  logic [2:0] state;
  logic [6:0] row;
  logic [6:0] lfsr;
  logic [6:0] gap_load;
  logic [7:0] gap_end;
  logic       row_in_gap;
  logic       collision;

  // The gap bottom can reach 96+24-1 = 119. It is computed in 8 bits so that a
  // larger GAP cannot wrap around and fake a gap near the top of the screen.
  assign gap_end    = {1'b0, gap_y} + {1'b0, GAP} - 8'd1;
  assign row_in_gap = ({1'b0, row} >= {1'b0, gap_y}) && ({1'b0, row} <= gap_end);
  assign collision  = (wall_x == PLAYER_X) &&
                      (({1'b0, player_y} < {1'b0, gap_y}) || ({1'b0, player_y} > gap_end));

  // The LFSR can reach 127. Values above 96 are folded down by 32 so that the
  // gap always fits on screen.
  assign gap_load = (lfsr <= GAP_MAX) ? lfsr : lfsr - 7'd32;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      row     <= 7'd0;
      wall_x  <= LAST_COL;
      gap_y   <= 7'd48;
      lfsr    <= SEED;
      touched <= 1'b0;
    end else begin
      // x^7 + x^6 + 1. The LFSR runs freely, so the gap taken at a wrap
      // depends on how long the game has been running.
      lfsr    <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      touched <= 1'b0;
      case (state)
        IDLE: begin
          // A frame_tick that arrives in any other state is dropped, not queued.
          if (go && frame_tick) begin
            state <= ERASE;
            row   <= 7'd0;
          end
        end
        ERASE: begin
          if (row == LAST_ROW) begin
            row   <= 7'd0;
            state <= STEP;
          end else begin
            row <= row + 7'd1;
          end
        end
        STEP: begin
          if (wall_x == 8'd0) begin
            wall_x <= LAST_COL;
            gap_y  <= gap_load;
          end else begin
            wall_x <= wall_x - 8'd1;
          end
          state <= DRAW;
        end
        DRAW: begin
          if (row == LAST_ROW) begin
            row   <= 7'd0;
            state <= CHECK;
          end else begin
            row <= row + 7'd1;
          end
        end
        CHECK: begin
          // On a hit the wall stays where it is. The next move starts by
          // erasing this same column.
          touched <= collision;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The pixel port is decoded from the state. An asynchronous reset therefore
  // silences plot and zeroes the port at once.
  always_comb begin
    plot       = 1'b0;
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'b000;
    case (state)
      ERASE: begin
        plot  = 1'b1;
        vga_x = wall_x;
        vga_y = row;
      end
      DRAW: begin
        plot       = !row_in_gap;
        vga_x      = wall_x;
        vga_y      = row;
        vga_colour = WALL_COLOUR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_wall.sv
// Directed/randomised bench for datapath_wall. It keeps a behavioural model of
// the wall column, the gap row and the free-running random source, and it
// checks pixel writes, collision pulses and reset behaviour against that model.
module tb_datapath_wall;
  localparam int PX   = 20;
  localparam int GAPH = 24;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic       frame_tick;
  logic [6:0] player_y;
  logic       touched;
  logic [7:0] wall_x;
  logic [6:0] gap_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;

  datapath_wall dut (
    .clk(clk), .reset(reset), .go(go), .frame_tick(frame_tick),
    .player_y(player_y), .touched(touched), .wall_x(wall_x), .gap_y(gap_y),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int mx;
  int mgap;
  int m_lfsr;

  // Model of the random source: shift left, and feed back the XOR of the
  // x^7 and x^6 terms into the low bit.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 'h5A;
    else       m_lfsr <= ((m_lfsr * 2) % 128) + (((m_lfsr / 64) + (m_lfsr / 32)) % 2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete move sequence. detailed: check every pixel. mess: drop go
  // during ERASE and send a second frame_tick during DRAW.
  task automatic run_seq(input bit detailed, input bit mess);
    int old_x;
    bit coll;
    @(negedge clk);
    go = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    old_x = mx;
    for (int k = 0; k < 120; k++) begin
      if (detailed) begin
        check("erase_plot", plot, 1);
        check("erase_x", vga_x, old_x);
        check("erase_y", vga_y, k);
        check("erase_colour", vga_colour, 0);
      end
      if (mess && k == 10) go = 1'b0;
      @(posedge clk); #1;
    end
    if (detailed) check("step_plot", plot, 0);
    if (mx == 0) begin
      mx = 159;
      mgap = (m_lfsr <= 96) ? m_lfsr : m_lfsr - 32;
    end else begin
      mx = mx - 1;
    end
    @(posedge clk); #1;
    if (mess) go = 1'b1;
    for (int k = 0; k < 120; k++) begin
      if (detailed) begin
        check("draw_plot", plot, (k < mgap || k > mgap + GAPH - 1));
        check("draw_x", vga_x, mx);
        check("draw_y", vga_y, k);
        check("draw_colour", vga_colour, 7);
      end
      frame_tick = (mess && k == 50);
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
    coll = (mx == PX) && (int'(player_y) < mgap || int'(player_y) > mgap + GAPH - 1);
    check("check_touched", touched, 0);
    if (detailed) check("check_plot", plot, 0);
    @(posedge clk); #1;
    check("touched_pulse", touched, coll);
    go = 1'b0;
    @(posedge clk); #1;
    check("touched_after", touched, 0);
    check("idle_plot", plot, 0);
    check("wall_x", wall_x, mx);
    check("gap_y", gap_y, mgap);
  endtask

  int plots;

  initial begin
    reset = 1'b1;
    go = 1'b0;
    frame_tick = 1'b0;
    player_y = 7'd60;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wall_x", wall_x, 159);
    check("rst_gap_y", gap_y, 48);
    check("rst_touched", touched, 0);
    check("rst_plot", plot, 0);
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    @(negedge clk);
    reset = 1'b0;
    mx = 159;
    mgap = 48;

    // A tick without go, or go without a tick, must not start a move.
    plots = 0;
    frame_tick = 1'b1;
    repeat (3) begin @(posedge clk); #1; plots += int'(plot); end
    frame_tick = 1'b0;
    go = 1'b1;
    repeat (3) begin @(posedge clk); #1; plots += int'(plot); end
    go = 1'b0;
    check("idle_no_start_plots", plots, 0);
    check("idle_wall_x", wall_x, 159);

    // First move after reset: erase x=159, then draw x=158 around the 48..71 gap.
    run_seq(1, 0);
    // Go is dropped and a second tick arrives in the middle of the move.
    run_seq(1, 1);
    plots = 0;
    go = 1'b1;
    repeat (20) begin @(posedge clk); #1; plots += int'(plot); end
    go = 1'b0;
    check("retick_ignored_plots", plots, 0);
    check("retick_wall_x", wall_x, 157);

    while (mx > 21) run_seq(0, 0);
    // At column 20 the player sits on the bottom row of the gap, so no hit.
    player_y = 7'd71;
    run_seq(1, 0);
    run_seq(0, 0);
    check("continue_to_19", wall_x, 19);

    // Reset arrives at DRAW row 50.
    @(negedge clk);
    go = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (121 + 50) begin @(posedge clk); #1; end
    mx = mx - 1;
    check("pre_reset_vga_y", vga_y, 50);
    check("pre_reset_vga_x", vga_x, mx);
    reset = 1'b1;
    #1;
    check("mid_reset_plot", plot, 0);
    check("mid_reset_vga_x", vga_x, 0);
    check("mid_reset_vga_y", vga_y, 0);
    check("mid_reset_colour", vga_colour, 0);
    check("mid_reset_wall_x", wall_x, 159);
    check("mid_reset_gap_y", gap_y, 48);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mx = 159;
    mgap = 48;
    plots = 0;
    repeat (130) begin @(posedge clk); #1; plots += int'(plot); end
    go = 1'b0;
    check("post_reset_no_plots", plots, 0);

    // Column 20 with the player above the gap: a hit is pulsed for exactly one cycle.
    player_y = 7'd60;
    while (mx > 21) run_seq(0, 0);
    player_y = 7'd10;
    run_seq(0, 0);
    repeat (5) begin @(posedge clk); #1; end
    check("hit_wall_held", wall_x, 20);
    check("hit_touched_low", touched, 0);
    // The next move starts by erasing the column where the hit happened.
    run_seq(1, 0);

    // Run down to column 0, then wrap and load a random gap.
    player_y = 7'd60;
    while (mx > 0) run_seq(0, 0);
    run_seq(1, 0);
    check("wrap_wall_x", wall_x, 159);
    check("wrap_gap_range", (gap_y <= 7'd96), 1);
    run_seq(0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/datapath_wall.md
DATAPATH_WALL -- requirements
Module: datapath_wall

Interface
REQ-001 SHALL have parameter PLAYER_X, default 8'd20, screen column occupied by the player.
REQ-002 SHALL have parameter GAP, default 7'd24, height in rows of the opening in the wall.
REQ-003 SHALL have parameter WALL_COLOUR, default 3'b111, colour used to draw the wall.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port go, input, 1 bit; wall-move enable from the wall controller, high while in its move state.
REQ-007 SHALL have port frame_tick, input, 1 bit; one-cycle pulse per frame.
REQ-008 SHALL have port player_y, input, 7 bits; player row, 0..119.
REQ-009 SHALL have port touched, output, 1 bit; one-cycle collision pulse to the wall controller.
REQ-010 SHALL have port wall_x, output, 8 bits; current wall column, 0..159.
REQ-011 SHALL have port gap_y, output, 7 bits; top row of the current gap.
REQ-012 SHALL have ports vga_x (8 bits), vga_y (7 bits), vga_colour (3 bits), plot (1 bit), all outputs to the VGA adapter.

Function
REQ-013 SHALL implement states IDLE, ERASE, STEP, DRAW, CHECK; state encoding is free.
REQ-014 IDLE: plot=0; go=1 and frame_tick=1 in the same cycle -> ERASE next cycle; otherwise stay in IDLE.
REQ-015 ERASE: row counter 0..119, one pixel per cycle, plot=1, vga_x=wall_x, vga_y=row, vga_colour=3'b000; after row 119 -> STEP (120 cycles).
REQ-016 STEP (1 cycle, plot=0): wall_x>0 -> wall_x-1; wall_x==0 -> wall_x=159 and gap_y loaded from the LFSR value; -> DRAW.
REQ-017 DRAW: row counter 0..119, vga_x=wall_x, vga_y=row, vga_colour=WALL_COLOUR; plot=1 only when row<gap_y or row>gap_y+GAP-1; after row 119 -> CHECK (120 cycles).
REQ-018 CHECK (1 cycle, plot=0): collision = (wall_x==PLAYER_X) and (player_y<gap_y or player_y>gap_y+GAP-1); -> IDLE.
REQ-019 touched SHALL be registered: high for exactly the one cycle after CHECK when collision=1; low at all other times.
REQ-020 On collision, wall_x and gap_y SHALL be held; the next move sequence starts by erasing that column.
REQ-021 frame_tick pulses outside IDLE SHALL be ignored, not queued.
REQ-022 Deassertion of go mid-sequence SHALL NOT abort it; the sequence completes through CHECK so the screen stays consistent.
REQ-023 LFSR SHALL be 7-bit, polynomial x^7+x^6+1, seed 7'h5A, advancing every clock.
REQ-024 Gap load value SHALL be the LFSR value if <=96, else LFSR-32, so gap_y is always in 0..96.
REQ-025 A full move sequence SHALL take 243 cycles from the accepting tick to touched (ERASE 120 + STEP 1 + DRAW 120 + CHECK 1 + 1).

Reset
REQ-026 reset=1 SHALL immediately force IDLE, with wall_x=159, gap_y=48, row counter=0, LFSR=7'h5A.
REQ-027 reset=1 SHALL immediately force touched=0, plot=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-028 reset asserted mid-ERASE or mid-DRAW SHALL abort the sequence, with no further plot pulses until a new go and frame_tick.

Verification
REQ-029 After reset, go=1 with a single frame_tick -> 120 black plots at x=159, y=0..119, then wall_x=158, then 96 plots at x=158 skipping rows 48..71, touched=0.
REQ-030 Preload wall_x=0 via repeated ticks (159 sequences) -> STEP wraps wall_x to 159 and gap_y takes the LFSR-derived value, always <=96.
REQ-031 wall_x reaches 20 with gap_y=48 and player_y=10 -> touched=1 for exactly one cycle, 243 cycles after the tick; wall_x stays 20 afterwards.
REQ-032 wall_x reaches 20 with player_y=60 inside the gap -> touched stays 0 and the wall continues to 19 on the next tick.
REQ-033 frame_tick pulsed again during DRAW, and go dropped during ERASE -> the second tick is ignored and the sequence still completes exactly once.
REQ-034 reset pulsed at DRAW row 50 -> plot=0 in the same cycle, state IDLE, wall_x=159.
